fp_cmp_resolve: RTL and testbench
=================================

FP_CMP_RESOLVE -- requirements
Module: fp_cmp_resolve

Interface
REQ-001 SHALL have parameter FPWID, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ce  input  1  clock enable; when 0, all state holds and i_ready is 0.
REQ-005 SHALL have port i_valid  input  1  input beat valid.
REQ-006 SHALL have port i_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port op  input  4  operation code, REQ-015.
REQ-008 SHALL have port a, b  input  FPWID each  IEEE 754 operands.
REQ-009 SHALL have port cmp  input  5  compare vector from the upstream compare stage, for the same a/b: [0]eq, [1]lt, [2]le, [3]magnitude-lt, [4]unordered.
REQ-010 SHALL have port tag  input  4  caller ID, carried through unchanged.
REQ-011 SHALL have port o_valid  output  1  result valid.
REQ-012 SHALL have port o_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports o (output, FPWID, result) and o_tag (output, 4, tag of result).
REQ-014 SHALL have ports nvx (output, 1, sticky invalid flag) and clr_nvx (input, 1, clears nvx).

Function
REQ-015 Opcodes: 0 SEQ, 1 SNE, 2 SLT, 3 SLE, 4 SGT, 5 SGE, 6 SUN, 7 SOR, 8 MIN, 9 MAX, 10 CMP; 11-15 reserved.
REQ-016 Boolean results (ops 0-7) SHALL be 0 or 1, zero-extended to FPWID.
REQ-017 With u=cmp[4]: SEQ=eq&!u; SNE=!SEQ; SLT=lt&!u; SLE=le&!u; SGT=!lt&!eq&!u; SGE=!lt&!u; SUN=u; SOR=!u.
REQ-018 CMP SHALL return cmp zero-extended to FPWID.
REQ-019 MIN/MAX, a and b both NaN: return canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0).
REQ-020 MIN/MAX, exactly one operand NaN: return the other operand.
REQ-021 MIN SHALL return a if lt, else b; MAX SHALL return b if lt, else a.
REQ-022 MIN/MAX with eq set: MIN returns whichever of a/b has sign 1, else a; MAX returns whichever has sign 0, else a. Covers +0/-0.
REQ-023 Reserved ops SHALL return 0 and not affect nvx.
REQ-024 Pipeline: two register stages, S1 (captured inputs) and S2 (output register driving o, o_tag, o_valid).
REQ-025 Handshake: a beat transfers when i_valid&i_ready; a result transfers when o_valid&o_ready.
REQ-026 i_ready = ce & (!S1.valid | advance1); advance1 = ce & (!o_valid | o_ready).
REQ-027 Latency: exactly 2 cycles from input transfer to o_valid, with o_ready high; throughput 1 beat per cycle.
REQ-028 While o_valid&!o_ready, o and o_tag SHALL hold stable; no beat lost or duplicated; 2 beats absorbed before i_ready drops.
REQ-029 Beats SHALL leave in input order, each result paired with its own tag.
REQ-030 nvx SHALL set when a beat loads S2 with op in {SLT,SLE,SGT,SGE,MIN,MAX} and cmp[4]=1.
REQ-031 clr_nvx SHALL clear nvx independent of ce; a set in the same cycle wins over clear.

Reset
REQ-032 On rst=1 at a clock edge, regardless of ce: S1.valid=0, o_valid=0, o=0, o_tag=0, nvx=0.
REQ-033 i_ready SHALL be 0 during reset and equal ce in the first cycle after reset.
REQ-034 A reset mid-operation SHALL discard all in-flight beats; none appear afterwards.

Verification
REQ-035 a=0x3F800000, b=0x40000000, cmp=5'b01110, op=SLT, tag=3, o_ready=1 -> o=1, o_tag=3 two cycles later; nvx stays 0.
REQ-036 a=0x7FC00000, b=0x3F800000, cmp=5'b10000, op=SLE -> o=0, nvx=1; then op=MIN, same operands -> o=0x3F800000; then clr_nvx -> nvx=0.
REQ-037 a=0x00000000, b=0x80000000, cmp=5'b00101, op=MIN -> o=0x80000000; op=MAX -> o=0x00000000; op=SEQ -> o=1.
REQ-038 Back-to-back beats with tags 0-7 and o_ready toggled pseudo-randomly -> outputs carry tags 0-7 in order, with o held stable while stalled.
REQ-039 o_ready=0 for 4 cycles with i_valid=1 -> exactly 2 beats accepted, then i_ready=0; o_ready=1 -> all 2 drain in order.
REQ-040 rst=1 for one cycle with 2 beats in flight -> o_valid=0 and nvx=0 next cycle; no stale result ever emerges.

Source files
------------

// File: rtl/fp_cmp_resolve.sv
// fp_cmp_resolve: 2-stage pipelined FP compare/min/max resolver (valid/ready in: op,a,b,cmp,tag; out: o,o_tag; sticky nvx with clr_nvx; ce gates all state)
module fp_cmp_resolve #(
  parameter int FPWID = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [3:0]       op,
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  input  logic [4:0]       cmp,
  input  logic [3:0]       tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FPWID-1:0] o,
  output logic [3:0]       o_tag,
  output logic             nvx,
  input  logic             clr_nvx
);
  localparam int EW = (FPWID == 64) ? 11 : (FPWID == 16) ? 5 : 8;
  localparam int FW = FPWID - 1 - EW;
  localparam logic [FPWID-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [FPWID-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [4:0]       s1_cmp_q, s1_cmp_d;
  logic [3:0]       s1_tag_q, s1_tag_d;
  logic             o_valid_q, o_valid_d;
  logic [FPWID-1:0] o_q, o_d;
  logic [3:0]       o_tag_q, o_tag_d;
  logic             nvx_q, nvx_d;
  logic             adv, eq, lt, le, u, a_nan, b_nan, inv_op, bool_r;
  logic [7:0]       bool_vec;
  logic [FPWID-1:0] min_v, max_v, res;
  always_comb begin
    adv        = ce & (!o_valid_q | o_ready);
    i_ready    = ce & !rst & (!s1_valid_q | adv);
    s1_valid_d = i_ready ? i_valid : s1_valid_q;
    s1_op_d    = i_ready ? op : s1_op_q;
    s1_a_d     = i_ready ? a : s1_a_q;
    s1_b_d     = i_ready ? b : s1_b_q;
    s1_cmp_d   = i_ready ? cmp : s1_cmp_q;
    s1_tag_d   = i_ready ? tag : s1_tag_q;
    eq         = s1_cmp_q[0];
    lt         = s1_cmp_q[1];
    le         = s1_cmp_q[2];
    u          = s1_cmp_q[4];
    a_nan      = (&s1_a_q[FPWID-2 -: EW]) & (|s1_a_q[FW-1:0]);
    b_nan      = (&s1_b_q[FPWID-2 -: EW]) & (|s1_b_q[FW-1:0]);
    bool_vec   = {!u, u, !lt & !u, !lt & !eq & !u, le & !u, lt & !u, !(eq & !u), eq & !u};
    bool_r     = bool_vec[s1_op_q[2:0]];
    min_v      = (a_nan & b_nan) ? QNAN : a_nan ? s1_b_q : b_nan ? s1_a_q :
                 eq ? ((!s1_a_q[FPWID-1] & s1_b_q[FPWID-1]) ? s1_b_q : s1_a_q) :
                 lt ? s1_a_q : s1_b_q;
    max_v      = (a_nan & b_nan) ? QNAN : a_nan ? s1_b_q : b_nan ? s1_a_q :
                 eq ? ((s1_a_q[FPWID-1] & !s1_b_q[FPWID-1]) ? s1_b_q : s1_a_q) :
                 lt ? s1_b_q : s1_a_q;
    res        = !s1_op_q[3]      ? {{(FPWID-1){1'b0}}, bool_r} :
                 s1_op_q == 4'd8  ? min_v :
                 s1_op_q == 4'd9  ? max_v :
                 s1_op_q == 4'd10 ? {{(FPWID-5){1'b0}}, s1_cmp_q} : '0;
    inv_op     = (s1_op_q >= 4'd2 && s1_op_q <= 4'd5) || s1_op_q == 4'd8 || s1_op_q == 4'd9;
    o_valid_d  = adv ? s1_valid_q : o_valid_q;
    o_d        = (adv & s1_valid_q) ? res : o_q;
    o_tag_d    = (adv & s1_valid_q) ? s1_tag_q : o_tag_q;
    nvx_d      = (adv & s1_valid_q & inv_op & u) | (nvx_q & !clr_nvx);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_q        <= '0;
      o_tag_q    <= '0;
      nvx_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      o_valid_q  <= o_valid_d;
      o_q        <= o_d;
      o_tag_q    <= o_tag_d;
      nvx_q      <= nvx_d;
    end
    s1_op_q  <= s1_op_d;
    s1_a_q   <= s1_a_d;
    s1_b_q   <= s1_b_d;
    s1_cmp_q <= s1_cmp_d;
    s1_tag_q <= s1_tag_d;
  end
  assign o_valid = o_valid_q;
  assign o       = o_q;
  assign o_tag   = o_tag_q;
  assign nvx     = nvx_q;
endmodule

// File: tb/tb_fp_cmp_resolve.sv
// tb_fp_cmp_resolve: scoreboard bench for fp_cmp_resolve with a behavioural reference model
module tb_fp_cmp_resolve;
  logic        clk = 0, rst = 1, ce = 1, i_valid = 0, o_ready = 1, clr_nvx = 0;
  logic        i_ready, o_valid, nvx;
  logic [3:0]  op = 0, tag = 0, o_tag;
  logic [31:0] a = 0, b = 0, o;
  logic [4:0]  cmp = 0;
  fp_cmp_resolve #(.FPWID(32)) dut (
    .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_ready(i_ready),
    .op(op), .a(a), .b(b), .cmp(cmp), .tag(tag),
    .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_tag(o_tag),
    .nvx(nvx), .clr_nvx(clr_nvx)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] res; logic [3:0] tag; int cyc; bit lat; } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0;
  bit          exp_nvx = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic bit is_nan(logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic logic [32:0] model(logic [3:0] f, logic [31:0] x, logic [31:0] y, logic [4:0] c);
    bit eqb = c[0], ltb = c[1], leb = c[2], un = c[4], bo = 0, inv;
    logic [31:0] r = 0;
    case (f)
      0: bo = eqb && !un;
      1: bo = !(eqb && !un);
      2: bo = ltb && !un;
      3: bo = leb && !un;
      4: bo = !ltb && !eqb && !un;
      5: bo = !ltb && !un;
      6: bo = un;
      7: bo = !un;
      default: bo = 0;
    endcase
    if (f <= 7) r = {31'b0, bo};
    else if (f == 10) r = {27'b0, c};
    else if (f == 8 || f == 9) begin
      if (is_nan(x) && is_nan(y)) r = 32'h7FC00000;
      else if (is_nan(x)) r = y;
      else if (is_nan(y)) r = x;
      else if (eqb) begin
        if (f == 8) r = x[31] ? x : (y[31] ? y : x);
        else        r = !x[31] ? x : (!y[31] ? y : x);
      end
      else if (f == 8) r = ltb ? x : y;
      else             r = ltb ? y : x;
    end
    inv = un && (f == 2 || f == 3 || f == 4 || f == 5 || f == 8 || f == 9);
    return {inv, r};
  endfunction
  task automatic push_exp(bit lat);
    logic [32:0] m;
    m = model(op, a, b, cmp);
    sb.push_back('{m[31:0], tag, cyc, lat});
    if (m[32]) exp_nvx = 1;
  endtask
  task automatic send(logic [3:0] f, logic [31:0] x, logic [31:0] y, logic [4:0] c, logic [3:0] t, bit lat);
    int n = 0;
    @(negedge clk);
    op = f; a = x; b = y; cmp = c; tag = t; i_valid = 1;
    #1;
    while (!i_ready) begin
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: i_ready 0 expected 1");
        i_valid = 0;
        return;
      end
      @(negedge clk);
      #1;
    end
    push_exp(lat);
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    i_valid = 0; o_ready = 1;
    while ((sb.size() != 0 || o_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_outstanding", sb.size(), 0);
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] v[8] = '{32'h0, 32'h80000000, 32'h3F800000, 32'hBF800000,
                          32'h7F800000, 32'h7FC00000, 32'h7F800001, 32'hFFC00000};
    int k = $urandom_range(0, 8);
    return (k == 8) ? $urandom : v[k];
  endfunction
  logic [31:0] prev_o;
  logic [3:0]  prev_tag;
  bit          prev_stall = 0;
  exp_t        e;
  always begin
    @(negedge clk);
    #4;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, o_valid}, 1);
        chk("hold_o", o, prev_o);
        chk("hold_tag", {28'b0, o_tag}, {28'b0, prev_tag});
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got tag %0d o %h expected no output", o_tag, o);
        end else begin
          e = sb.pop_front();
          chk("result", o, e.res);
          chk("tag", {28'b0, o_tag}, {28'b0, e.tag});
          if (e.lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_o = o;
      prev_tag = o_tag;
    end
  end
  initial begin
    int acc, sent;
    bit pend;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_i_ready", {31'b0, i_ready}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_o_valid", {31'b0, o_valid}, 0);
    chk("rst_o", o, 0);
    chk("rst_o_tag", {28'b0, o_tag}, 0);
    chk("rst_nvx", {31'b0, nvx}, 0);
    chk("post_rst_i_ready", {31'b0, i_ready}, 1);
    ce = 0;
    #1;
    chk("ce0_i_ready", {31'b0, i_ready}, 0);
    ce = 1;
    send(2, 32'h3F800000, 32'h40000000, 5'b01110, 3, 1);
    drain();
    chk("slt_nvx", {31'b0, nvx}, 0);
    send(3, 32'h7FC00000, 32'h3F800000, 5'b10000, 1, 1);
    send(8, 32'h7FC00000, 32'h3F800000, 5'b10000, 2, 1);
    drain();
    chk("nan_nvx_set", {31'b0, nvx}, {31'b0, exp_nvx});
    @(negedge clk); clr_nvx = 1;
    @(negedge clk); clr_nvx = 0;
    #1;
    chk("clr_nvx", {31'b0, nvx}, 0);
    exp_nvx = 0;
    send(8, 32'h00000000, 32'h80000000, 5'b00101, 4, 1);
    send(9, 32'h00000000, 32'h80000000, 5'b00101, 5, 1);
    send(0, 32'h00000000, 32'h80000000, 5'b00101, 6, 1);
    send(8, 32'h80000000, 32'h00000000, 5'b00101, 7, 1);
    send(9, 32'h80000000, 32'h00000000, 5'b00101, 8, 1);
    send(8, 32'h7F800001, 32'hFFC00000, 5'b10000, 9, 1);
    send(9, 32'h40000000, 32'h7FC00000, 5'b10000, 10, 1);
    send(10, 32'h0, 32'h0, 5'b01110, 11, 1);
    drain();
    exp_nvx = 0;
    @(negedge clk); clr_nvx = 1;
    @(negedge clk); clr_nvx = 0;
    send(12, 32'h7FC00000, 32'h0, 5'b10000, 12, 1);
    send(15, 32'h3F800000, 32'h0, 5'b00000, 13, 1);
    drain();
    chk("reserved_nvx", {31'b0, nvx}, 0);
    o_ready = 0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op = 4'(k); a = 32'h3F800000; b = 32'h40000000; cmp = 5'b01110; tag = 4'(k + 8); i_valid = 1;
      #1;
      if (i_ready) begin push_exp(0); acc++; end
    end
    chk("stall_accepted", acc, 2);
    @(negedge clk);
    i_valid = 0;
    #1;
    chk("stall_i_ready", {31'b0, i_ready}, 0);
    ce = 0;
    @(negedge clk);
    #1;
    chk("ce0_hold_i_ready", {31'b0, i_ready}, 0);
    chk("ce0_hold_o_valid", {31'b0, o_valid}, 1);
    ce = 1;
    drain();
    o_ready = 0;
    send(2, 32'h7FC00000, 32'h0, 5'b10000, 1, 0);
    send(3, 32'h7FC00000, 32'h0, 5'b10000, 2, 0);
    @(negedge clk);
    i_valid = 0;
    #1;
    chk("pre_rst_nvx", {31'b0, nvx}, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    exp_nvx = 0;
    #1;
    chk("midrst_o_valid", {31'b0, o_valid}, 0);
    chk("midrst_nvx", {31'b0, nvx}, 0);
    o_ready = 1;
    repeat (10) @(negedge clk);
    sent = 0;
    pend = 0;
    for (int c = 0; c < 3000 && sent < 300; c++) begin
      @(negedge clk);
      o_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if ($urandom_range(0, 4) != 0) begin
          op = 4'($urandom_range(0, 15)); a = pick(); b = pick(); cmp = 5'($urandom);
          tag = 4'(sent); i_valid = 1; pend = 1;
        end else i_valid = 0;
      end
      #1;
      if (pend && i_ready) begin
        push_exp(0);
        sent++;
        pend = 0;
      end
    end
    chk("random_sent", sent, 300);
    drain();
    chk("random_nvx", {31'b0, nvx}, {31'b0, exp_nvx});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
